// File: rtl/idr_pkg.sv
// idr_pkg: shared decode constants, next-PC source encodings, exception
// vectors and the interrupt FSM state type for the decode-stage redirect
// controller. Optional opcodes are controlled by IDR_BLEZ_BGTZ_EN.
package idr_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  // R-type function codes that redirect fetch
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  // Next-PC source selects seen by the fetch stage
  localparam logic [2:0] PCSRC_SEQ    = 3'd0;
  localparam logic [2:0] PCSRC_BRANCH = 3'd1;
  localparam logic [2:0] PCSRC_JUMP   = 3'd2;
  localparam logic [2:0] PCSRC_INT    = 3'd3;
  localparam logic [2:0] PCSRC_EXC    = 3'd4;

  // Default trap targets applied by fetch
  localparam logic [31:0] INT_VECTOR_ADDR = 32'h8000_0004;
  localparam logic [31:0] EXC_VECTOR_ADDR = 32'h8000_0008;

`ifdef IDR_BLEZ_BGTZ_EN
  localparam logic BLEZ_BGTZ_EN = 1'b1;
`else
  localparam logic BLEZ_BGTZ_EN = 1'b0;
`endif

  // Interrupt tracking: RUN (idle), PEND (waiting for a takeable
  // instruction), SERV (handler running in kernel space)
  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_PEND = 2'd1,
    ST_SERV = 2'd2
  } int_state_e;

  // True for every opcode the pipeline knows how to execute.
  function automatic logic opcode_defined(input logic [5:0] op);
    logic known;
    case (op)
      OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI,
      OP_LUI, OP_LW, OP_SW:  known = 1'b1;
      OP_BLEZ, OP_BGTZ:      known = BLEZ_BGTZ_EN;
      default:               known = 1'b0;
    endcase
    return known;
  endfunction

  // True when a nonzero destination register is read by the ID instruction.
  function automatic logic reads_reg(input logic [4:0] wreg,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       rt_src);
    return (wreg != 5'd0) && ((wreg == rs) || (rt_src && (wreg == rt)));
  endfunction

endpackage

// File: rtl/id_redirect_ctrl_if.sv
// id_redirect_ctrl_if: fetch-stage next-PC interface. The decode stage
// (master) receives the fetched instruction and returns redirect controls;
// the fetch stage (slave) owns the PC mux.
interface id_redirect_ctrl_if;

  // Fetch -> decode
  logic [31:0] instructionIF;
  logic [31:0] PCIF;
  logic [31:0] PCplus4IF;

  // Decode -> fetch
  logic [2:0]  PCSrcID;
  logic [31:0] branchaddrID;
  logic [31:0] jumpaddrID;
  logic [31:0] int_vector;
  logic [31:0] exc_vector;
  logic        stall;
  logic        flush;
  logic        exception;

  modport master (
    input  instructionIF, PCIF, PCplus4IF,
    output PCSrcID, branchaddrID, jumpaddrID, int_vector, exc_vector,
           stall, flush, exception
  );

  modport slave (
    output instructionIF, PCIF, PCplus4IF,
    input  PCSrcID, branchaddrID, jumpaddrID, int_vector, exc_vector,
           stall, flush, exception
  );

endinterface

// File: rtl/idr_branch_cmp.sv
// idr_branch_cmp: branch opcode recognition, outcome evaluation and
// target computation for the ID instruction. blez/bgtz are recognised
// only when IDR_BLEZ_BGTZ_EN is defined.
module idr_branch_cmp
  import idr_pkg::*;
(
  input  logic [5:0]  opcode_i,
  input  logic [15:0] imm16_i,
  input  logic [31:0] pcplus4_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  output logic        is_branch_o,
  output logic        taken_o,
  output logic [31:0] branch_addr_o
);

  logic [31:0] offset;

  // Word offset, sign-extended; the add wraps at 32 bits.
  assign offset        = {{14{imm16_i[15]}}, imm16_i, 2'b00};
  assign branch_addr_o = pcplus4_i + offset;

  // Classify the opcode and evaluate its condition on the forwarded operands.
  always_comb begin
    is_branch_o = 1'b0;
    taken_o     = 1'b0;
    case (opcode_i)
      OP_BEQ: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_data_i == rt_data_i);
      end
      OP_BNE: begin
        is_branch_o = 1'b1;
        taken_o     = (rs_data_i != rt_data_i);
      end
`ifdef IDR_BLEZ_BGTZ_EN
      OP_BLEZ: begin
        is_branch_o = 1'b1;
        taken_o     = ($signed(rs_data_i) <= 32'sd0);
      end
      OP_BGTZ: begin
        is_branch_o = 1'b1;
        taken_o     = ($signed(rs_data_i) > 32'sd0);
      end
`endif
      default: begin
        is_branch_o = 1'b0;
        taken_o     = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/id_redirect_ctrl.sv
// id_redirect_ctrl: IF/ID pipeline register plus decode-stage redirect
// control (branches, jumps, load-use and branch-operand stalls, undefined
// opcode exceptions, external interrupts). Optional blez/bgtz support is
// enabled with the IDR_BLEZ_BGTZ_EN macro.
module id_redirect_ctrl
  import idr_pkg::*;
#(
  parameter logic [31:0] INT_VECTOR = INT_VECTOR_ADDR,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_ADDR
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       intterupt,
  id_redirect_ctrl_if.master         fetch,
  input  logic [31:0]                rs_data,
  input  logic [31:0]                rt_data,
  input  logic                       ex_memread,
  input  logic                       ex_regwrite,
  input  logic [4:0]                 ex_wreg,
  input  logic                       mem_memread,
  input  logic [4:0]                 mem_wreg,
  output logic [31:0]                instructionID,
  output logic [31:0]                PCID,
  output logic [31:0]                PCplus4ID,
  output logic                       validID,
  output logic                       id_bubble,
  output logic [31:0]                epc
);

  // IF/ID and trap state
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q,    pc_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] epc_q,   epc_d;
  int_state_e  state_q;

  // Decode fields
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        rt_is_src;
  logic        is_jr;
  logic        is_jump;
  logic        is_branch;
  logic        br_taken;
  logic [31:0] branch_addr;

  // Hazards and events
  logic        loaduse;
  logic        brhaz;
  logic        exc;
  logic        take_int;
  logic        stall_w;
  logic        redirect;
  logic        flush_w;
  logic [2:0]  pcsrc;

  assign opcode    = instr_q[31:26];
  assign funct     = instr_q[5:0];
  assign rs        = instr_q[25:21];
  assign rt        = instr_q[20:16];
  assign rt_is_src = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);
  assign is_jr     = (opcode == OP_RTYPE) &&
                     ((funct == FN_JR) || (funct == FN_JALR));
  assign is_jump   = (opcode == OP_J) || (opcode == OP_JAL) || is_jr;

  idr_branch_cmp u_branch_cmp (
    .opcode_i      (opcode),
    .imm16_i       (instr_q[15:0]),
    .pcplus4_i     (pc4_q),
    .rs_data_i     (rs_data),
    .rt_data_i     (rt_data),
    .is_branch_o   (is_branch),
    .taken_o       (br_taken),
    .branch_addr_o (branch_addr)
  );

  // A load in EX cannot forward in time for any ID consumer; a branch or
  // register jump resolved here also needs an EX ALU result or MEM load data.
  assign loaduse = ex_memread && reads_reg(ex_wreg, rs, rt, rt_is_src);
  assign brhaz   = (is_branch || is_jr) &&
                   ((ex_regwrite && reads_reg(ex_wreg, rs, rt, rt_is_src)) ||
                    (mem_memread && reads_reg(mem_wreg, rs, rt, rt_is_src)));

  // Exceptions outrank interrupts, which outrank stalls; interrupts are
  // only taken on a valid user-space instruction so the handler is not
  // re-entered from kernel code.
  assign exc      = valid_q && !opcode_defined(opcode);
  assign take_int = (state_q == ST_PEND) && valid_q && !pc_q[31] && !exc;
  assign stall_w  = valid_q && !exc && !take_int && (loaduse || brhaz);
  assign redirect = valid_q && !stall_w && ((is_branch && br_taken) || is_jump);
  assign flush_w  = exc || take_int || redirect;

  // Next-PC source select in priority order.
  always_comb begin
    pcsrc = PCSRC_SEQ;
    if (exc)                                  pcsrc = PCSRC_EXC;
    else if (take_int)                        pcsrc = PCSRC_INT;
    else if (stall_w)                         pcsrc = PCSRC_SEQ;
    else if (valid_q && is_branch && br_taken) pcsrc = PCSRC_BRANCH;
    else if (valid_q && is_jump)              pcsrc = PCSRC_JUMP;
    else                                      pcsrc = PCSRC_SEQ;
  end

  // Fetch-stage controls
  assign fetch.PCSrcID      = pcsrc;
  assign fetch.branchaddrID = branch_addr;
  assign fetch.jumpaddrID   = is_jr ? rs_data : {pc4_q[31:28], instr_q[25:0], 2'b00};
  assign fetch.int_vector   = INT_VECTOR;
  assign fetch.exc_vector   = EXC_VECTOR;
  assign fetch.stall        = stall_w;
  assign fetch.flush        = flush_w;
  assign fetch.exception    = exc;

  // Pipeline register and trap outputs
  assign instructionID = instr_q;
  assign PCID          = pc_q;
  assign PCplus4ID     = pc4_q;
  assign validID       = valid_q;
  assign epc           = epc_q;
  assign id_bubble     = stall_w || exc || take_int || !valid_q;

  // Next IF/ID contents: hold on stall, otherwise take fetch output and
  // mark it dead if this cycle redirects; capture resume PC on a trap.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    epc_d   = epc_q;
    if (!stall_w) begin
      instr_d = fetch.instructionIF;
      pc_d    = fetch.PCIF;
      pc4_d   = fetch.PCplus4IF;
      valid_d = !flush_w;
    end
    if (exc || take_int) begin
      epc_d = pc_q;
    end
  end

  // IF/ID and epc registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 32'd0;
      pc_q    <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
      epc_q   <= 32'd0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
      epc_q   <= epc_d;
    end
  end

  // Interrupt FSM: latch a request in RUN, serve it once, and rearm only
  // after execution is back in user space. An exception freezes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else if (!exc) begin
      case (state_q)
        ST_RUN:  if (intterupt)                state_q <= ST_PEND;
        ST_PEND: if (take_int)                 state_q <= ST_SERV;
        ST_SERV: if (valid_q && !pc_q[31])     state_q <= ST_RUN;
        default:                               state_q <= ST_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_redirect_ctrl.sv
// tb_id_redirect_ctrl: directed stimulus with literal expectations, plus a
// cycle-by-cycle behavioural model of the decode stage compared at negedge.
`timescale 1ns/1ps
module tb_id_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        intterupt = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        ex_memread = 1'b0;
  logic        ex_regwrite = 1'b0;
  logic [4:0]  ex_wreg = 5'd0;
  logic        mem_memread = 1'b0;
  logic [4:0]  mem_wreg = 5'd0;
  logic [31:0] instructionID, PCID, PCplus4ID, epc;
  logic        validID, id_bubble;

  id_redirect_ctrl_if fif ();

  id_redirect_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .intterupt     (intterupt),
    .fetch         (fif),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .ex_memread    (ex_memread),
    .ex_regwrite   (ex_regwrite),
    .ex_wreg       (ex_wreg),
    .mem_memread   (mem_memread),
    .mem_wreg      (mem_wreg),
    .instructionID (instructionID),
    .PCID          (PCID),
    .PCplus4ID     (PCplus4ID),
    .validID       (validID),
    .id_bubble     (id_bubble),
    .epc           (epc)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Model state: the instruction sitting in ID, trap PC, interrupt phase
  // (0 idle, 1 waiting for a takeable instruction, 2 in handler).
  logic [31:0] m_instr = 0, m_pc = 0, m_pc4 = 0, m_epc = 0;
  logic        m_valid = 0;
  int          m_st = 0;
  logic [31:0] n_instr, n_pc, n_pc4, n_epc;
  logic        n_valid;
  int          n_st;
  bit          chk_en = 0;

  logic [2:0]  e_src;
  logic        e_exc, e_ti, e_stall, e_flush, e_bub, e_taken, e_jmp, e_br, e_jr;
  logic [31:0] e_baddr, e_jaddr;
  logic signed [31:0] e_off;

  function automatic bit op_known(input logic [5:0] op);
    case (op)
      6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b,
      6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
`ifdef IDR_BLEZ_BGTZ_EN
      6'h06, 6'h07: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit uses_reg(input logic [4:0] r, input logic [31:0] ins);
    bit rt_src;
    rt_src = (ins[31:26] == 6'h00) || (ins[31:26] == 6'h04) ||
             (ins[31:26] == 6'h05) || (ins[31:26] == 6'h2b);
    return (r != 5'd0) && ((r == ins[25:21]) || (rt_src && (r == ins[20:16])));
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      e_jr  = (m_instr[31:26] == 6'h00) && ((m_instr[5:0] == 6'h08) || (m_instr[5:0] == 6'h09));
      e_jmp = (m_instr[31:26] == 6'h02) || (m_instr[31:26] == 6'h03) || e_jr;
      e_br  = (m_instr[31:26] == 6'h04) || (m_instr[31:26] == 6'h05);
      e_taken = 1'b0;
      if (m_instr[31:26] == 6'h04) e_taken = (rs_data == rt_data);
      if (m_instr[31:26] == 6'h05) e_taken = (rs_data != rt_data);
`ifdef IDR_BLEZ_BGTZ_EN
      if (m_instr[31:26] == 6'h06) begin e_br = 1'b1; e_taken = ($signed(rs_data) <= 0); end
      if (m_instr[31:26] == 6'h07) begin e_br = 1'b1; e_taken = ($signed(rs_data) > 0); end
`endif
      e_off   = $signed(m_instr[15:0]);
      e_baddr = m_pc4 + 32'(e_off * 4);
      e_jaddr = e_jr ? rs_data : {m_pc4[31:28], m_instr[25:0], 2'b00};
      e_exc   = m_valid && !op_known(m_instr[31:26]);
      e_ti    = (m_st == 1) && m_valid && !m_pc[31] && !e_exc;
      e_stall = m_valid && !e_exc && !e_ti &&
                ((ex_memread && uses_reg(ex_wreg, m_instr)) ||
                 ((e_br || e_jr) && ((ex_regwrite && uses_reg(ex_wreg, m_instr)) ||
                                     (mem_memread && uses_reg(mem_wreg, m_instr)))));
      if (e_exc)                          e_src = 3'd4;
      else if (e_ti)                      e_src = 3'd3;
      else if (e_stall)                   e_src = 3'd0;
      else if (m_valid && e_br && e_taken) e_src = 3'd1;
      else if (m_valid && e_jmp)          e_src = 3'd2;
      else                                e_src = 3'd0;
      e_flush = e_exc || e_ti || (!e_stall && m_valid && ((e_br && e_taken) || e_jmp));
      e_bub   = e_stall || e_exc || e_ti || !m_valid;

      chk("m_pcsrc",  32'(fif.PCSrcID),   32'(e_src));
      chk("m_stall",  32'(fif.stall),     32'(e_stall));
      chk("m_flush",  32'(fif.flush),     32'(e_flush));
      chk("m_exc",    32'(fif.exception), 32'(e_exc));
      chk("m_bubble", 32'(id_bubble),     32'(e_bub));
      chk("m_valid",  32'(validID),       32'(m_valid));
      chk("m_instr",  instructionID,      m_instr);
      chk("m_pc",     PCID,               m_pc);
      chk("m_pc4",    PCplus4ID,          m_pc4);
      chk("m_epc",    epc,                m_epc);
      chk("m_baddr",  fif.branchaddrID,   e_baddr);
      chk("m_jaddr",  fif.jumpaddrID,     e_jaddr);

      n_instr = m_instr; n_pc = m_pc; n_pc4 = m_pc4; n_valid = m_valid;
      n_epc = m_epc; n_st = m_st;
      if (!e_stall) begin
        n_instr = fif.instructionIF; n_pc = fif.PCIF; n_pc4 = fif.PCplus4IF;
        n_valid = !e_flush;
      end
      if (e_exc || e_ti) n_epc = m_pc;
      if (!e_exc) begin
        if (m_st == 0 && intterupt)               n_st = 1;
        else if (m_st == 1 && e_ti)               n_st = 2;
        else if (m_st == 2 && m_valid && !m_pc[31]) n_st = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      m_instr = 0; m_pc = 0; m_pc4 = 0; m_valid = 0; m_epc = 0; m_st = 0;
      chk_en = 1;
    end else if (chk_en) begin
      m_instr = n_instr; m_pc = n_pc; m_pc4 = n_pc4; m_valid = n_valid;
      m_epc = n_epc; m_st = n_st;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic set_if(input logic [31:0] instr, input logic [31:0] pc);
    fif.instructionIF = instr;
    fif.PCIF          = pc;
    fif.PCplus4IF     = pc + 32'd4;
  endtask

  // One transaction: advance a clock, then present the next fetched word.
  task automatic step(input logic [31:0] instr, input logic [31:0] pc);
    @(posedge clk);
    #1;
    set_if(instr, pc);
    $display("step t=%0t IF pc=%h instr=%h | ID pc=%h valid=%0d", $time, pc, instr, PCID, validID);
  endtask

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam logic [31:0] BEQ   = 32'h1022_0003; // beq $1,$2,+3
  localparam logic [31:0] ADD   = 32'h0103_4820; // add $9,$8,$3
  localparam logic [31:0] BAD   = 32'hFD00_0000; // opcode 0x3f, rs=$8
  localparam logic [31:0] BLEZ  = 32'h1820_0002; // blez $1,+2
  localparam logic [31:0] JMP   = 32'h0800_0040; // j 0x100
  localparam logic [31:0] JR    = 32'h03E0_0008; // jr $31
  localparam logic [31:0] BNE   = 32'h1485_FFFF; // bne $4,$5,-1

  initial begin
    set_if(BEQ, 32'h10);
    rs_data = 32'd5; rt_data = 32'd5;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid",  32'(validID),     32'd0);
    chk("rst_pcsrc",  32'(fif.PCSrcID), 32'd0);
    chk("rst_bubble", 32'(id_bubble),   32'd1);
    chk("rst_epc",    epc,              32'd0);
    chk("rst_instr",  instructionID,    32'd0);
    chk("rst_flush",  32'(fif.flush),   32'd0);
    chk("int_vector", fif.int_vector,   32'h8000_0004);
    reset = 1'b0;

    // taken beq
    step(NOP, 32'h14);
    @(negedge clk);
    chk("beq_valid", 32'(validID),      32'd1);
    chk("beq_pcsrc", 32'(fif.PCSrcID),  32'd1);
    chk("beq_addr",  fif.branchaddrID,  32'h20);
    chk("beq_flush", 32'(fif.flush),    32'd1);
    step(ADD, 32'h20);
    @(negedge clk);
    chk("beq_kill", 32'(validID), 32'd0);

    // load-use stall
    step(NOP, 32'h24);
    ex_memread = 1'b1; ex_wreg = 5'd8;
    @(negedge clk);
    chk("lu_stall",  32'(fif.stall), 32'd1);
    chk("lu_bubble", 32'(id_bubble), 32'd1);
    step(NOP, 32'h24);
    ex_memread = 1'b0;
    @(negedge clk);
    chk("lu_hold",    instructionID,   ADD);
    chk("lu_release", 32'(fif.stall),  32'd0);

    // interrupt
    step(NOP, 32'h28);
    step(NOP, 32'h3c);
    step(NOP, 32'h40);
    intterupt = 1'b1;
    step(NOP, 32'h44);
    intterupt = 1'b0;
    @(negedge clk);
    chk("int_pc",    PCID,              32'h40);
    chk("int_pcsrc", 32'(fif.PCSrcID),  32'd3);
    chk("int_flush", 32'(fif.flush),    32'd1);
    step(NOP, 32'h8000_0004);
    intterupt = 1'b1;
    @(negedge clk);
    chk("int_epc", epc, 32'h40);
    step(NOP, 32'h44);
    @(negedge clk);
    chk("serv_kernel", 32'(fif.PCSrcID), 32'd0);
    step(NOP, 32'h48);
    intterupt = 1'b0;
    @(negedge clk);
    chk("serv_user", 32'(fif.PCSrcID), 32'd0);
    step(BAD, 32'h80);
    @(negedge clk);
    chk("run_again", 32'(fif.PCSrcID), 32'd0);

    // undefined opcode with a simultaneous load-use match
    step(NOP, 32'h84);
    ex_memread = 1'b1; ex_wreg = 5'd8;
    @(negedge clk);
    chk("exc_pcsrc", 32'(fif.PCSrcID),   32'd4);
    chk("exc_flag",  32'(fif.exception), 32'd1);
    chk("exc_stall", 32'(fif.stall),     32'd0);
    step(BLEZ, 32'h90);
    ex_memread = 1'b0;
    @(negedge clk);
    chk("exc_epc", epc, 32'h80);

    // blez on a negative operand
    step(NOP, 32'h94);
    rs_data = 32'hFFFF_FFFF;
    @(negedge clk);
`ifdef IDR_BLEZ_BGTZ_EN
    chk("blez_pcsrc", 32'(fif.PCSrcID),   32'd1);
    chk("blez_addr",  fif.branchaddrID,   32'h9c);
`else
    chk("blez_pcsrc", 32'(fif.PCSrcID),   32'd4);
    chk("blez_exc",   32'(fif.exception), 32'd1);
`endif

    // direct jump
    step(JMP, 32'ha0);
    step(NOP, 32'ha4);
    @(negedge clk);
    chk("j_pcsrc", 32'(fif.PCSrcID), 32'd2);
    chk("j_addr",  fif.jumpaddrID,   32'h100);

    // jr waiting on an EX result
    step(JR, 32'hb0);
    step(NOP, 32'hb4);
    rs_data = 32'h1234; ex_regwrite = 1'b1; ex_wreg = 5'd31;
    @(negedge clk);
    chk("jr_stall", 32'(fif.stall),   32'd1);
    chk("jr_hold",  32'(fif.PCSrcID), 32'd0);
    step(NOP, 32'hb4);
    ex_regwrite = 1'b0;
    @(negedge clk);
    chk("jr_pcsrc", 32'(fif.PCSrcID), 32'd2);
    chk("jr_addr",  fif.jumpaddrID,   32'h1234);

    // bne waiting on a MEM load, then not taken
    step(BNE, 32'hc0);
    step(NOP, 32'hc4);
    rs_data = 32'd1; rt_data = 32'd1; mem_memread = 1'b1; mem_wreg = 5'd5;
    @(negedge clk);
    chk("bne_stall", 32'(fif.stall), 32'd1);
    step(NOP, 32'hc4);
    mem_memread = 1'b0;
    @(negedge clk);
    chk("bne_pcsrc", 32'(fif.PCSrcID),  32'd0);
    chk("bne_addr",  fif.branchaddrID,  32'hc0);

    // pending interrupt held off by kernel code, then discarded by reset
    step(NOP, 32'h8000_0010);
    step(NOP, 32'h8000_0014);
    intterupt = 1'b1;
    step(NOP, 32'h8000_0018);
    intterupt = 1'b0;
    @(negedge clk);
    chk("pend_kernel", 32'(fif.PCSrcID), 32'd0);
    step(NOP, 32'he0);
    reset = 1'b1;
    step(NOP, 32'he0);
    reset = 1'b0;
    step(NOP, 32'he4);
    @(negedge clk);
    chk("rst_drop_pc",    PCID,             32'he0);
    chk("rst_drop_pcsrc", 32'(fif.PCSrcID), 32'd0);

    step(NOP, 32'he8);
    step(NOP, 32'hec);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_redirect_ctrl.md
# id_redirect_ctrl

Decode-stage redirect controller and IF/ID pipeline register for the MIPS pipeline. Holds the instruction fetched by IF and resolves branches, jumps, load-use and branch-operand hazards, undefined-opcode exceptions and external interrupts. It drives `PCSrcID`, `branchaddrID`, `jumpaddrID`, `stall`, `flush` and `exception` back into the fetch stage. It is the producer end of the fetch-stage next-PC interface.

## Interface
Parameters:
- `INT_VECTOR`, 32'h80000004, target the fetch stage applies for `PCSrcID`=3 (informational; fetch owns the mux)
- `EXC_VECTOR`, 32'h80000008, target the fetch stage applies for `PCSrcID`=4 (informational)

Ports:
- `clk`  in  1  sole clock, rising edge
- `reset`  in  1  synchronous, active-high
- `intterupt`  in  1  external interrupt request, level
- `instructionIF`, `PCIF`, `PCplus4IF`  in  32 each  fetch-stage outputs
- `rs_data`, `rt_data`  in  32 each  forwarded ID operands
- `ex_memread`, `ex_regwrite`  in  1 each; `ex_wreg`  in  5  EX-stage destination info
- `mem_memread`  in  1; `mem_wreg`  in  5  MEM-stage load destination info
- `instructionID`, `PCID`, `PCplus4ID`  out  32 each  IF/ID register contents
- `validID`  out  1  ID holds a real instruction
- `PCSrcID`  out  3  0=seq, 1=branch, 2=jump, 3=interrupt, 4=exception
- `branchaddrID`, `jumpaddrID`  out  32 each  redirect targets
- `stall`, `flush`, `exception`  out  1 each  fetch-stage controls
- `id_bubble`  out  1  ID instruction enters EX as nop
- `epc`  out  32  resume address of the last interrupt or exception

## Operation
- **Decode**
  - rs = instr[25:21], rt = instr[20:16].
  - rt is a source for R-type, beq, bne and sw.
  - Branch ops: beq 0x04, bne 0x05. blez 0x06 and bgtz 0x07 are branch ops only under the configuration macro.
  - Jumps: j 0x02, jal 0x03, R-type funct 0x08 (jr), R-type funct 0x09 (jalr).
  - Defined opcodes: 0x00, 0x02–0x05, 0x08–0x0d, 0x0f, 0x23, 0x2b.
- **Targets** (driven continuously)
  - `branchaddrID` = `PCplus4ID` + sext(imm16)<<2, 32-bit wrap.
  - `jumpaddrID` = `rs_data` for jr/jalr; otherwise {`PCplus4ID`[31:28], instr[25:0], 2'b00}.
- **Hazards**
  - `loaduse` = `ex_memread` && `ex_wreg`≠0 && `ex_wreg` matches a source.
  - `brhaz` applies when ID is a branch, jr or jalr, and either:
    - `ex_regwrite` && `ex_wreg`≠0 && `ex_wreg` matches a source, or
    - `mem_memread` && `mem_wreg`≠0 && `mem_wreg` matches a source.
- **Events**
  - `exc` = `validID` && opcode undefined.
  - `take_int` = state PEND && `validID` && !`PCID`[31] && !`exc`.
  - `stall` = `validID` && !`exc` && !`take_int` && (`loaduse` || `brhaz`).
- **Priority**: exc > take_int > stall > taken branch > jump > sequential. `PCSrcID` is 4/3/0/1/2/0 in that order.
- **Redirect outputs**
  - `flush` = `exc` || `take_int` || (!`stall` && `validID` && (taken branch || jump)).
  - `id_bubble` = `stall` || `exc` || `take_int` || !`validID`.
  - `exception` = `exc`.
- **IF/ID register**
  - If `stall`: hold all fields.
  - Otherwise load `instructionIF`, `PCIF`, `PCplus4IF`, with `validID` ← !`flush`.
- **epc**: on `exc` or `take_int`, `epc` ← `PCID`.
- **Interrupt FSM** (RUN, PEND, SERV)
  - RUN → PEND when `intterupt`=1.
  - PEND → SERV on `take_int`.
  - SERV → RUN on `validID` && !`PCID`[31].
  - `intterupt` is ignored in PEND and SERV.
  - `exc` leaves the state unchanged.
  - PEND persists while ID is invalid or in kernel space.
- With `validID`=0, every redirect output is 0 except `id_bubble`.

## Timing
- Reset: `instructionID`, `PCID`, `PCplus4ID`, `epc` = 0; `validID` = 0; state RUN. Consequently `PCSrcID`, `stall`, `flush`, `exception` = 0 and `id_bubble` = 1.
- All redirect outputs are combinational from registered ID state and the hazard inputs. Fetch applies them at the next edge.
- A taken branch or jump costs 1 bubble. Each hazard stall lasts one cycle per asserting condition.
- Interrupt latency: `intterupt` sampled at edge N gives PEND from N+1; `PCSrcID`=3 in the first cycle afterward with a takeable ID instruction.
- Simultaneous events:
  - `stall` with a pending interrupt: the interrupt wins and `stall`=0.
  - Reset mid-PEND or mid-SERV returns to RUN and discards the request.

## Configuration
- `IDR_BLEZ_BGTZ_EN`
  - Defined: 0x06 blez (taken if `rs_data` signed ≤ 0) and 0x07 bgtz (taken if signed > 0) are branches with hazard checks.
  - Undefined: both opcodes raise `exc`.

## Structure
- Package `idr_pkg`:
  - opcode and funct constants
  - `PCSrcID` encodings 0–4
  - `INT_VECTOR` and `EXC_VECTOR` values
  - FSM state typedef (RUN, PEND, SERV)
- Sub-module `idr_branch_cmp`:
  - computes taken for the branch opcodes from `rs_data`/`rt_data`
  - computes `branchaddrID`
- Everything else lives in `id_redirect_ctrl`.

## Test plan
- Reset for 2 cycles → all registered outputs 0, `PCSrcID`=0, `id_bubble`=1. On release, the first fetched instruction loads with `validID`=1.
- beq $1,$2,+3 at `PCID`=0x10, `rs_data`=`rt_data`=5 → `PCSrcID`=1, `branchaddrID`=0x20, `flush`=1. Next cycle `validID`=0.
- `ex_memread`=1, `ex_wreg`=8, ID = add $9,$8,$3 → `stall`=1 and `id_bubble`=1 for exactly one cycle, IF/ID held. `stall`=0 once `ex_memread` drops.
- `intterupt` pulse with `PCID`=0x40 → PEND. Next cycle: `PCSrcID`=3, `epc`=0x40, `flush`=1, state SERV. A second pulse is ignored until `PCID`=0x44 arrives valid, then RUN.
- Opcode 0x3f at `PCID`=0x80 → `PCSrcID`=4, `exception`=1, `epc`=0x80. Branch logic and `stall` are suppressed.
- blez with `rs_data`=0xFFFFFFFF → `PCSrcID`=1 with `IDR_BLEZ_BGTZ_EN` defined; `PCSrcID`=4 and `exception`=1 without it.
